csr_file: RTL

- Parametrised machine-mode CSR block; successor to the combinational CSR ALU.
- Folds the SET/CLEAR/PASS read-modify-write datapath together with real CSR storage: NUM_SCRATCH scratch registers, a cycle counter and an instret counter.
- Sits in the execute stage. Returns the old CSR value for rd writeback and commits the new value at the clock edge.

---
 rtl/csr_file.sv | 130 +++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// rtl/csr_file.sv - Machine-mode CSR file: scratch CSRs, cycle/instret counters, SET/CLEAR/PASS RMW datapath
module csr_file #(
    parameter int          WIDTH         = 32,
    parameter int          NUM_SCRATCH   = 4,
    parameter logic [11:0] SCRATCH_BASE  = 12'h340,
    parameter int          COUNTER_WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             csr_en_i,
    input  logic [1:0]       csr_control_i,
    input  logic [11:0]      csr_addr_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic             write_suppress_i,
    input  logic             retire_i,
    output logic [WIDTH-1:0] csr_rdata_o,
    output logic             illegal_o
);
    localparam logic [1:0] CSR_READ  = 2'b00;
    localparam logic [1:0] CSR_PASS  = 2'b01;
    localparam logic [1:0] CSR_SET   = 2'b10;
    localparam logic [1:0] CSR_CLEAR = 2'b11;
    localparam int HI_W = COUNTER_WIDTH - WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    logic [WIDTH-1:0]         scratch_q [NUM_SCRATCH];
    logic [COUNTER_WIDTH-1:0] cycle_q;
    logic [COUNTER_WIDTH-1:0] instret_q;

    logic [NUM_SCRATCH-1:0] scratch_hit;
    logic [WIDTH-1:0]       scratch_rdata;
    logic                   ctr_hit;
    logic                   ro_range;
    logic                   mapped;
    logic [WIDTH-1:0]       old_val;
    logic [WIDTH-1:0]       new_val;
    logic                   wants_write;
    logic                   illegal;
    logic                   do_write;
    logic                   wr_cycle_lo;
    logic                   wr_cycle_hi;
    logic                   wr_instret_lo;
    logic                   wr_instret_hi;

    always_comb begin
        scratch_hit   = '0;
        scratch_rdata = '0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (csr_addr_i == SCRATCH_BASE + 12'(i)) begin
                scratch_hit[i] = 1'b1;
                scratch_rdata  = scratch_q[i];
            end
        end
    end

    // The C-range addresses are read-only shadows of the same counter halves.
    always_comb begin
        ctr_hit = 1'b1;
        old_val = '0;
        case (csr_addr_i)
            12'hB00, 12'hC00: old_val = cycle_q[WIDTH-1:0];
            12'hB80, 12'hC80: old_val = WIDTH'(cycle_q[COUNTER_WIDTH-1:WIDTH]);
            12'hB02, 12'hC02: old_val = instret_q[WIDTH-1:0];
            12'hB82, 12'hC82: old_val = WIDTH'(instret_q[COUNTER_WIDTH-1:WIDTH]);
            default: begin
                ctr_hit = 1'b0;
                old_val = scratch_rdata;
            end
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (csr_control_i)
            CSR_READ:  new_val = old_val;
            CSR_PASS:  new_val = operand_a_i;
            CSR_SET:   new_val = old_val | operand_a_i;
            CSR_CLEAR: new_val = old_val & ~operand_a_i;
        endcase
    end

    assign ro_range    = ctr_hit && (csr_addr_i[11:8] == 4'hC);
    assign mapped      = ctr_hit || (|scratch_hit);
    assign wants_write = csr_en_i &&
                         ((csr_control_i == CSR_PASS) ||
                          (((csr_control_i == CSR_SET) || (csr_control_i == CSR_CLEAR)) && !write_suppress_i));
    assign illegal     = csr_en_i && (!mapped || (wants_write && ro_range));
    assign do_write    = wants_write && mapped && !ro_range && !illegal;

    assign wr_cycle_lo   = do_write && (csr_addr_i == 12'hB00);
    assign wr_cycle_hi   = do_write && (csr_addr_i == 12'hB80);
    assign wr_instret_lo = do_write && (csr_addr_i == 12'hB02);
    assign wr_instret_hi = do_write && (csr_addr_i == 12'hB82);

    assign csr_rdata_o = (csr_en_i && !illegal) ? old_val : '0;
    assign illegal_o   = illegal;

    // A write to either half of a counter replaces its increment for that edge; no carry on write.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (do_write && scratch_hit[i]) begin
                    scratch_q[i] <= new_val;
                end
            end

            if (wr_cycle_lo) begin
                cycle_q[WIDTH-1:0] <= new_val;
            end else if (wr_cycle_hi) begin
                cycle_q[COUNTER_WIDTH-1:WIDTH] <= new_val[HI_W-1:0];
            end else begin
                cycle_q <= cycle_q + CNT_ONE;
            end

            if (wr_instret_lo) begin
                instret_q[WIDTH-1:0] <= new_val;
            end else if (wr_instret_hi) begin
                instret_q[COUNTER_WIDTH-1:WIDTH] <= new_val[HI_W-1:0];
            end else if (retire_i) begin
                instret_q <= instret_q + CNT_ONE;
            end
        end
    end
endmodule
